// File: rtl/seq_restoring_divider_if.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider_if
//   Operand/result bundle for the sequential restoring divider.
//   Clock and reset/load stay as plain ports on the divider itself.
//
//   iQ    : dividend (unsigned), sampled while nRst is low
//   iM    : divisor  (unsigned), sampled while nRst is low
//   oQ    : registered quotient
//   oR    : registered remainder
//   oDone : high while oQ/oR hold a valid result
//
//   master : the controller side (drives operands, reads results)
//   slave  : the divider side
// -----------------------------------------------------------------------------
interface seq_restoring_divider_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] iQ;
    logic [WIDTH-1:0] iM;
    logic [WIDTH-1:0] oQ;
    logic [WIDTH-1:0] oR;
    logic             oDone;

    modport master (
        output iQ,
        output iM,
        input  oQ,
        input  oR,
        input  oDone
    );

    modport slave (
        input  iQ,
        input  iM,
        output oQ,
        output oR,
        output oDone
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//   Unsigned restoring shift/subtract divider, one quotient bit per clock.
//   nRst low loads the operands (and clears the outputs); releasing nRst
//   starts a run that finishes after exactly WIDTH rising edges, at which
//   point oQ/oR/oDone are registered and then held until the next load.
//
//   Ports:
//     iClk  in   system clock, rising edge
//     nRst  in   synchronous active-low reset / operand load
//     bus   slave modport of seq_restoring_divider_if
//             (iQ, iM in; oQ, oR, oDone out)
//
//   Divide by zero needs no special path: every trial subtraction of 0
//   succeeds, so the quotient comes out all ones and the partial remainder
//   simply accumulates the dividend.
// -----------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic                    iClk,
    input  logic                    nRst,
    seq_restoring_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    // Iteration state
    logic [WIDTH:0]   a_q,    a_d;      // partial remainder, one guard bit
    logic [WIDTH-1:0] qreg_q, qreg_d;   // dividend shifting out, quotient in
    logic [WIDTH-1:0] mreg_q;           // latched divisor
    logic [CW-1:0]    cnt_q,  cnt_d;

    // Result registers
    logic [WIDTH-1:0] oq_q,   oq_d;
    logic [WIDTH-1:0] or_q,   or_d;
    logic             done_q, done_d;

    // One restoring step
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   trial;
    logic             running;

    assign running = (cnt_q < CW'(WIDTH));

    always_comb begin
        a_d    = a_q;
        qreg_d = qreg_q;
        cnt_d  = cnt_q;
        oq_d   = oq_q;
        or_d   = or_q;
        done_d = done_q;

        // {A,Qreg} << 1: the dividend MSB moves into the remainder LSB
        a_sh  = {a_q[WIDTH-1:0], qreg_q[WIDTH-1]};
        q_sh  = {qreg_q[WIDTH-2:0], 1'b0};
        trial = a_sh - {1'b0, mreg_q};

        if (running) begin
            if (trial[WIDTH]) begin
                // Subtraction went negative: restore (keep shifted value)
                a_d    = a_sh;
                qreg_d = q_sh;
            end else begin
                a_d    = trial;
                qreg_d = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
            end
            cnt_d = cnt_q + CW'(1);

            // Last step publishes the result on the same edge it is formed
            if (cnt_q == CW'(WIDTH - 1)) begin
                oq_d   = qreg_d;
                or_d   = a_d[WIDTH-1:0];
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!nRst) begin
            // Load has priority over everything, including the completion edge
            a_q    <= '0;
            qreg_q <= bus.iQ;
            mreg_q <= bus.iM;
            cnt_q  <= '0;
            oq_q   <= '0;
            or_q   <= '0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            qreg_q <= qreg_d;
            cnt_q  <= cnt_d;
            oq_q   <= oq_d;
            or_q   <= or_d;
            done_q <= done_d;
        end
    end

    assign bus.oQ    = oq_q;
    assign bus.oR    = or_q;
    assign bus.oDone = done_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;
    localparam int W = 4;

    logic iClk = 1'b0;
    logic nRst = 1'b0;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .iClk (iClk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #5 iClk = ~iClk;

    int n_vec = 0;
    int n_err = 0;

    // Observations of one run (filled by run_div, compared by each test)
    logic [W-1:0] got_q, got_r;
    int           done_edge;
    bit           leak;

    // Advance one rising edge, then settle 1 time unit before sampling/driving
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Load operands for one edge, release, and watch up to 10 edges for oDone.
    task automatic run_div(input logic [W-1:0] q, input logic [W-1:0] m);
        nRst   = 1'b0;
        bus.iQ = q;
        bus.iM = m;
        tick();
        nRst      = 1'b1;
        done_edge = 0;
        leak      = 1'b0;
        got_q     = '0;
        got_r     = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.oDone) begin
                done_edge = k;
                got_q     = bus.oQ;
                got_r     = bus.oR;
                break;
            end else if (bus.oQ !== 4'd0 || bus.oR !== 4'd0) begin
                leak = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        nRst   = 1'b0;
        bus.iQ = 4'd0;
        bus.iM = 4'd1;
        tick();
        tick();
        n_vec++;
        if (bus.oQ !== 4'd0 || bus.oR !== 4'd0 || bus.oDone !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got q=%0d r=%0d done=%b, want 0 0 0", bus.oQ, bus.oR, bus.oDone);
        end
    endtask

    task automatic test_basic();
        nRst   = 1'b0;
        bus.iQ = 4'd7;
        bus.iM = 4'd3;
        tick();
        nRst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_vec++;
            if (bus.oQ !== 4'd0 || bus.oR !== 4'd0 || bus.oDone !== 1'b0) begin
                n_err++;
                $display("FAIL basic_pre edge%0d: got q=%0d r=%0d done=%b, want 0 0 0",
                         k, bus.oQ, bus.oR, bus.oDone);
            end
        end
        tick();
        n_vec++;
        if (bus.oQ !== 4'd2 || bus.oR !== 4'd1 || bus.oDone !== 1'b1) begin
            n_err++;
            $display("FAIL basic_7/3: got q=%0d r=%0d done=%b, want 2 1 1", bus.oQ, bus.oR, bus.oDone);
        end
        // Change operands while idle; result must hold
        bus.iQ = 4'd15;
        bus.iM = 4'd1;
        for (int k = 0; k < 6; k++) tick();
        n_vec++;
        if (bus.oQ !== 4'd2 || bus.oR !== 4'd1 || bus.oDone !== 1'b1) begin
            n_err++;
            $display("FAIL basic_hold: got q=%0d r=%0d done=%b, want 2 1 1", bus.oQ, bus.oR, bus.oDone);
        end
    endtask

    task automatic test_back_to_back();
        run_div(4'd4, 4'd2);
        n_vec++;
        if (done_edge != 4 || got_q !== 4'd2 || got_r !== 4'd0 || leak) begin
            n_err++;
            $display("FAIL b2b_4/2: got edge=%0d q=%0d r=%0d leak=%b, want 4 2 0 0", done_edge, got_q, got_r, leak);
        end
        nRst   = 1'b0;
        bus.iQ = 4'd3;
        bus.iM = 4'd3;
        tick();
        n_vec++;
        if (bus.oQ !== 4'd0 || bus.oR !== 4'd0 || bus.oDone !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_clear: got q=%0d r=%0d done=%b, want 0 0 0", bus.oQ, bus.oR, bus.oDone);
        end
        run_div(4'd3, 4'd3);
        n_vec++;
        if (done_edge != 4 || got_q !== 4'd1 || got_r !== 4'd0 || leak) begin
            n_err++;
            $display("FAIL b2b_3/3: got edge=%0d q=%0d r=%0d leak=%b, want 4 1 0 0", done_edge, got_q, got_r, leak);
        end
    endtask

    task automatic test_edges();
        run_div(4'd15, 4'd1);
        n_vec++;
        if (done_edge != 4 || got_q !== 4'd15 || got_r !== 4'd0) begin
            n_err++;
            $display("FAIL edge_15/1: got edge=%0d q=%0d r=%0d, want 4 15 0", done_edge, got_q, got_r);
        end
        run_div(4'd5, 4'd7);
        n_vec++;
        if (done_edge != 4 || got_q !== 4'd0 || got_r !== 4'd5) begin
            n_err++;
            $display("FAIL edge_5/7: got edge=%0d q=%0d r=%0d, want 4 0 5", done_edge, got_q, got_r);
        end
        run_div(4'd15, 4'd15);
        n_vec++;
        if (done_edge != 4 || got_q !== 4'd1 || got_r !== 4'd0) begin
            n_err++;
            $display("FAIL edge_15/15: got edge=%0d q=%0d r=%0d, want 4 1 0", done_edge, got_q, got_r);
        end
        run_div(4'd0, 4'd9);
        n_vec++;
        if (done_edge != 4 || got_q !== 4'd0 || got_r !== 4'd0) begin
            n_err++;
            $display("FAIL edge_0/9: got edge=%0d q=%0d r=%0d, want 4 0 0", done_edge, got_q, got_r);
        end
    endtask

    task automatic test_div_zero();
        run_div(4'd9, 4'd0);
        n_vec++;
        if (done_edge != 4 || got_q !== 4'd15 || got_r !== 4'd9) begin
            n_err++;
            $display("FAIL divzero_9/0: got edge=%0d q=%0d r=%0d, want 4 15 9", done_edge, got_q, got_r);
        end
    endtask

    task automatic test_reload();
        // Two load edges; the later operands must win: 14/3 = 4 r 2
        nRst   = 1'b0;
        bus.iQ = 4'd7;
        bus.iM = 4'd3;
        tick();
        bus.iQ = 4'd14;
        bus.iM = 4'd3;
        tick();
        nRst = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        n_vec++;
        if (bus.oQ !== 4'd4 || bus.oR !== 4'd2 || bus.oDone !== 1'b1) begin
            n_err++;
            $display("FAIL reload_14/3: got q=%0d r=%0d done=%b, want 4 2 1", bus.oQ, bus.oR, bus.oDone);
        end
    endtask

    task automatic test_abort();
        nRst   = 1'b0;
        bus.iQ = 4'd7;
        bus.iM = 4'd3;
        tick();
        nRst = 1'b1;
        tick();
        tick();
        nRst   = 1'b0;
        bus.iQ = 4'd12;
        bus.iM = 4'd5;
        tick();
        n_vec++;
        if (bus.oQ !== 4'd0 || bus.oR !== 4'd0 || bus.oDone !== 1'b0) begin
            n_err++;
            $display("FAIL abort_clear: got q=%0d r=%0d done=%b, want 0 0 0", bus.oQ, bus.oR, bus.oDone);
        end
        nRst = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        n_vec++;
        if (bus.oDone !== 1'b0) begin
            n_err++;
            $display("FAIL abort_early_done: got done=%b after 3 edges, want 0", bus.oDone);
        end
        tick();
        n_vec++;
        if (bus.oQ !== 4'd2 || bus.oR !== 4'd2 || bus.oDone !== 1'b1) begin
            n_err++;
            $display("FAIL abort_12/5: got q=%0d r=%0d done=%b, want 2 2 1", bus.oQ, bus.oR, bus.oDone);
        end
        // Load on the completion edge wins over completion
        nRst   = 1'b0;
        bus.iQ = 4'd11;
        bus.iM = 4'd2;
        tick();
        nRst = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        nRst = 1'b0;
        tick();
        n_vec++;
        if (bus.oQ !== 4'd0 || bus.oR !== 4'd0 || bus.oDone !== 1'b0) begin
            n_err++;
            $display("FAIL abort_on_done_edge: got q=%0d r=%0d done=%b, want 0 0 0", bus.oQ, bus.oR, bus.oDone);
        end
    endtask

    task automatic test_isolation();
        // 13/4 = 3 r 1; operands scrambled mid-run must not matter
        nRst   = 1'b0;
        bus.iQ = 4'd13;
        bus.iM = 4'd4;
        tick();
        nRst = 1'b1;
        tick();
        bus.iQ = 4'd2;
        bus.iM = 4'd9;
        tick();
        bus.iQ = 4'd15;
        bus.iM = 4'd0;
        tick();
        tick();
        n_vec++;
        if (bus.oQ !== 4'd3 || bus.oR !== 4'd1 || bus.oDone !== 1'b1) begin
            n_err++;
            $display("FAIL isolation_13/4: got q=%0d r=%0d done=%b, want 3 1 1", bus.oQ, bus.oR, bus.oDone);
        end
    endtask

    task automatic test_exhaustive();
        for (int q = 0; q < 16; q++) begin
            for (int m = 1; m < 16; m++) begin
                logic [W-1:0] eq, er;
                eq = 4'(q / m);
                er = 4'(q % m);
                run_div(4'(q), 4'(m));
                n_vec++;
                if (done_edge != 4 || got_q !== eq || got_r !== er || leak) begin
                    n_err++;
                    $display("FAIL exh_%0d/%0d: got edge=%0d q=%0d r=%0d leak=%b, want 4 %0d %0d 0",
                             q, m, done_edge, got_q, got_r, leak, eq, er);
                end
            end
        end
    endtask

    initial begin
        bus.iQ = '0;
        bus.iM = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_edges();
        test_div_zero();
        test_reload();
        test_abort();
        test_isolation();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
